bsg_carry_save_resolve_iterative: RTL
=====================================

// Module: bsg_carry_save_resolve_iterative
// PURPOSE
//  Consumer end of the carry-save reduction path. Accepts one carry-save pair (A,B) per op.
//  Resolves A+B into a binary sum using a stride_p-bit carry-propagate slice over several cycles.
//  Sits after the 4-2 CSA tree in the iterative multipliers; trades latency for area on the final CPA.
// PARAMETERS
//  width_p   32  operand and result width in bits; sum is taken mod 2^width_p
//  stride_p   8  bits resolved per cycle, 1 <= stride_p <= width_p
//  chunks_lp  -  derived: ceil(width_p/stride_p); this is the number of busy cycles
// PORTS
//  clk_i      in   1        single clock
//  reset_i    in   1        synchronous, active-high reset
//  opA_i      in   width_p  carry-save vector A
//  opB_i      in   width_p  carry-save vector B
//  v_i        in   1        input valid
//  ready_o    out  1        block can accept; a transfer happens when v_i & ready_o
//  sum_o      out  width_p  (A+B) mod 2^width_p; stable while v_o=1
//  c_o        out  1        carry out of bit width_p-1 (unsigned overflow)
//  v_o        out  1        result valid
//  yumi_i     in   1        consumer takes the result; legal only when v_o=1
// BEHAVIOUR
//  - States: eIdle -> eBusy -> eDone -> eIdle.
//  - eIdle: ready_o=1. On v_i:
//      - latch A and B
//      - carry=0, chunk counter=0
//      - go to eBusy.
//  - eBusy: each cycle adds the low stride_p bits of A and B plus carry.
//      - The slice result is written to sum chunk[cnt]; the carry-out is registered.
//      - A and B shift right by stride_p; cnt increments.
//      - After chunk chunks_lp-1, go to eDone.
//  - Last chunk when width_p%stride_p!=0: operands are zero-padded above width_p-1.
//      - c_o = slice sum bit at position width_p.
//  - eDone: v_o=1, sum_o/c_o held. On yumi_i, go to eIdle.
//  - Latency: accepted at edge N, so v_o rises after edge N+chunks_lp.
//      - stride_p=width_p gives 1 busy cycle.
//  - ready_o=0 in eBusy and in eDone (except as noted under CONFIGURATION). v_i is ignored then.
//  - yumi_i without v_o is illegal; the bench asserts on it.
//  - Reset, including mid-operation:
//      - next state eIdle; v_o=0, sum_o=0, c_o=0, cnt=0, carry=0
//      - ready_o=0 while reset_i=1, and 1 on the first cycle after.
//      - Any in-flight partial sum is discarded.
//  - Signed (sign-extended) tree outputs resolve correctly under the mod-2^width_p rule; c_o is then meaningless.
// CONFIGURATION
//  - Macro BSG_CARRY_SAVE_RESOLVE_BACK_TO_BACK_EN.
//  - Defined: in eDone, ready_o=yumi_i.
//      - If v_i and yumi_i are both high, the new op is latched and the state goes straight to eBusy.
//      - Throughput is one op per chunks_lp+1 cycles.
//  - Undefined: ready_o only in eIdle; one bubble cycle per op.
//      - Throughput is one op per chunks_lp+2 cycles.
// STRUCTURE
//  - Package bsg_carry_save_resolve_pkg holds:
//      - typedef enum logic [1:0] {eIdle, eBusy, eDone} state_e
//      - function chunks(width, stride) for the ceil divide
//  - One sub-module: bsg_carry_save_chunk_adder #(stride_p).
//      - Ports: a_i, b_i, c_i -> s_o, c_o.
//      - Purely combinational; the top owns all state.
//  - Top holds the FSM, the counter (clog2 of chunks_lp), the A/B shift registers, the carry flop and the sum register.
// TESTING
//  - width_p=16, stride_p=4, A=0xFFFF, B=0x0001.
//      - Expect sum_o=0x0000, c_o=1.
//      - v_o rises 4 cycles after the accept.
//  - width_p=16, stride_p=4, A=0x1234, B=0x4321 -> sum_o=0x5555, c_o=0.
//  - width_p=10, stride_p=4 (3 chunks), A=0x3FF, B=0x3FF.
//      - Expect sum_o=0x3FE, c_o=1 after 3 busy cycles.
//  - Assert reset_i in the 2nd busy cycle.
//      - Next cycle: v_o=0, ready_o=1.
//      - A fresh op A=5, B=7 then yields sum_o=12.
//  - Hold yumi_i low for 5 cycles in eDone.
//      - sum_o and v_o must stay stable; v_i is ignored (ready_o=0).
//  - Back-to-back, yumi_i and v_i high together in eDone:
//      - Macro defined: the 2nd op is accepted that cycle; the 2nd v_o comes chunks_lp+1 cycles after the 1st.
//      - Macro undefined: the 2nd v_o comes chunks_lp+2 cycles after the 1st.

Source files
------------

// File: rtl/bsg_carry_save_resolve_pkg.sv
// Shared types and helpers for the iterative carry-save resolver.
//   state_e : FSM encoding used by bsg_carry_save_resolve_iterative
//   chunks  : ceiling divide giving the number of busy cycles per op
package bsg_carry_save_resolve_pkg;

  typedef enum logic [1:0] {eIdle, eBusy, eDone} state_e;

  function automatic int chunks(input int width, input int stride);
    return (width + stride - 1) / stride;
  endfunction

endpackage

// File: rtl/bsg_carry_save_chunk_adder.sv
// Purely combinational stride_p-bit carry-propagate slice.
// Ports:
//   a_i, b_i : stride_p-bit addend slices
//   c_i      : carry in from the previous slice
//   s_o      : stride_p-bit slice sum
//   c_o      : carry out of the slice
module bsg_carry_save_chunk_adder #(
  parameter int stride_p = 8
) (
  input  logic [stride_p-1:0] a_i,
  input  logic [stride_p-1:0] b_i,
  input  logic                c_i,
  output logic [stride_p-1:0] s_o,
  output logic                c_o
);

  // Zero-extend by one bit so the carry out falls into the top bit.
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{stride_p{1'b0}}, c_i};

endmodule

// File: rtl/bsg_carry_save_resolve_iterative.sv
// Resolves a carry-save pair (A,B) into a binary sum, stride_p bits per cycle.
// Optional feature macro: BSG_CARRY_SAVE_RESOLVE_BACK_TO_BACK_EN lets a new op
// be accepted in the same cycle the previous result is taken.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   opA_i, opB_i   : carry-save vectors, latched when v_i & ready_o
//   v_i / ready_o  : input handshake
//   sum_o, c_o     : (A+B) mod 2^width_p and carry out of bit width_p-1
//   v_o / yumi_i   : output handshake
module bsg_carry_save_resolve_iterative
  import bsg_carry_save_resolve_pkg::*;
#(
  parameter int width_p  = 32,
  parameter int stride_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] opA_i,
  input  logic [width_p-1:0] opB_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] sum_o,
  output logic               c_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int chunks_lp   = chunks(width_p, stride_p);
  localparam int cntW_lp     = (chunks_lp > 1) ? $clog2(chunks_lp) : 1;
  localparam int tailBits_lp = width_p % stride_p;
  localparam logic [cntW_lp-1:0] lastCnt_lp = cntW_lp'(chunks_lp - 1);

  state_e               state_q, state_d;
  logic [width_p-1:0]   a_q, a_d, b_q, b_d;
  logic [width_p-1:0]   sum_q, sum_d;
  logic                 carry_q, carry_d;
  logic                 c_q, c_d;
  logic [cntW_lp-1:0]   cnt_q, cnt_d;
  logic [stride_p-1:0]  sliceSum;
  logic                 sliceCarry;
  logic                 lastCarry;
  logic                 accept;

  // The low slice of the shifting operands is always the chunk being resolved;
  // right shifts fill with zeros, which gives the zero padding on a short last chunk.
  bsg_carry_save_chunk_adder #(.stride_p(stride_p)) adder (
    .a_i (a_q[stride_p-1:0]),
    .b_i (b_q[stride_p-1:0]),
    .c_i (carry_q),
    .s_o (sliceSum),
    .c_o (sliceCarry)
  );

  // When the last chunk is short, the carry out of bit width_p-1 lands inside
  // the slice sum rather than at its carry out.
  if (tailBits_lp == 0) begin : g_even
    assign lastCarry = sliceCarry;
  end else begin : g_tail
    assign lastCarry = sliceSum[tailBits_lp];
  end

  // State register: reset discards any in-flight partial result.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and handshake logic. Accepting a new op is shared between the
  // idle state and (optionally) the done state, so it is applied after the case.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    ready_o = 1'b0;
    v_o     = 1'b0;
    accept  = 1'b0;

    unique case (state_q)
      eIdle: begin
        ready_o = 1'b1;
        accept  = v_i;
      end
      eBusy: begin
        a_d     = a_q >> stride_p;
        b_d     = b_q >> stride_p;
        carry_d = sliceCarry;
        for (int i = 0; i < width_p; i++) begin
          if (cnt_q == cntW_lp'(i / stride_p)) sum_d[i] = sliceSum[i % stride_p];
        end
        if (cnt_q == lastCnt_lp) begin
          c_d     = lastCarry;
          state_d = eDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      eDone: begin
        v_o = 1'b1;
`ifdef BSG_CARRY_SAVE_RESOLVE_BACK_TO_BACK_EN
        ready_o = yumi_i;
        accept  = v_i & yumi_i;
`endif
        if (yumi_i) state_d = eIdle;
      end
      default: state_d = eIdle;
    endcase

    if (accept) begin
      a_d     = opA_i;
      b_d     = opB_i;
      carry_d = 1'b0;
      cnt_d   = '0;
      state_d = eBusy;
    end

    if (reset_i) ready_o = 1'b0;
  end

  assign sum_o = sum_q;
  assign c_o   = c_q;

endmodule
